// File: rtl/uart_rcv.sv
// 8N1 UART receiver: two-flop RX synchroniser, mid-bit sampling, sticky rdy flag.
// rx_data/frm_err are held in their own registers so they only change on a completed frame.
module uart_rcv #(
    parameter int BAUD_DIV = 5208,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RECV  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rx_m;
    logic        rx_s;
    logic        rx_d;
    logic [12:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic [7:0]  data_q;
    logic        rdy_q;
    logic        frm_q;
    logic        start_det;
    logic        sample;
    logic        done;

    // Synchroniser flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    always_comb begin
        start_det = (state == IDLE) && rx_d && !rx_s;
        sample    = (state != IDLE) && (baud_cnt == 13'd0);
        done      = (state == RECV) && sample && (bit_cnt == 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_det) state_nxt = START;
            START:   if (sample) state_nxt = rx_s ? IDLE : RECV;
            RECV:    if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Loads are N-1 so the distance between samples is exactly N clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (start_det) begin
            baud_cnt <= 13'(HALF_DIV - 1);
            bit_cnt  <= '0;
        end else if (sample) begin
            baud_cnt <= 13'(BAUD_DIV - 1);
            bit_cnt  <= bit_cnt + 4'd1;
        end else if (state != IDLE) begin
            baud_cnt <= baud_cnt - 13'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            data_q    <= '0;
            frm_q     <= 1'b0;
        end else if (done) begin
            data_q <= shift_reg;
            frm_q  <= ~rx_s;
        end else if (sample && (state == RECV)) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
        end
    end

    // Completion wins over a simultaneous start clear or consumer clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else if (done) begin
            rdy_q <= 1'b1;
        end else if (start_det || clr_rdy) begin
            rdy_q <= 1'b0;
        end
    end

    assign rx_data = data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_q;

endmodule

// File: tb/tb_uart_rcv.sv
// Directed bench for uart_rcv, run at a reduced baud divisor to keep frames short.
// A negedge monitor pops the expected byte/frm_err for every rising edge of rdy.
module tb_uart_rcv;

    localparam int B = 64;
    localparam int H = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_rise_cyc = 0;
    int rise_cnt = 0;
    int lat = 0;
    logic rdy_seen = 1'b0;
    logic [8:0] mon_e;
    logic [8:0] exp_q[$];

    uart_rcv #(.BAUD_DIV(B), .HALF_DIV(H)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (rx),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each rdy rise must match the oldest expected {frm_err, byte}.
    always @(negedge clk) begin
        if (rdy && !rdy_seen) begin
            rise_cnt++;
            last_rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, mon_e[7:0]});
                check("frm_err", {31'd0, frm_err}, {31'd0, mon_e[8]});
            end
        end
        rdy_seen = rdy;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic expect_it, input logic chk_drop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        if (expect_it) exp_q.push_back({~stop, d});
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            for (int k = 0; k < B; k++) begin
                @(negedge clk);
                if (chk_drop && i == 0 && k == 5) check("drop_on_start", {31'd0, rdy}, 32'd0);
            end
        end
    endtask

    initial begin
        logic [9:0] pf;

        // Reset values
        repeat (5) @(negedge clk);
        check("rst_rdy", {31'd0, rdy}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_frm", {31'd0, frm_err}, 32'd0);
        check("rst_state", 32'(dut.state), 32'd0);
        rst_n = 1'b1;
        idle(2 * B);

        // 8'hA5 with latency window, then consumer clear
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        lat = last_rise_cyc - start_cyc;
        check("a5_rise", rise_cnt, 32'd1);
        check("a5_lat_lo", {31'd0, lat >= (9 * B + H)}, 32'd1);
        check("a5_lat_hi", {31'd0, lat <= (9 * B + H + 5)}, 32'd1);
        check("a5_rdy", {31'd0, rdy}, 32'd1);
        idle(B);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        check("clr_rdy", {31'd0, rdy}, 32'd0);

        // Back-to-back 8'h00 / 8'hFF, no clr_rdy
        idle(2 * B);
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        check("b2b_rdy1", {31'd0, rdy}, 32'd1);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1);
        idle(B);
        check("b2b_rise", rise_cnt, 32'd3);
        check("b2b_rdy2", {31'd0, rdy}, 32'd1);

        // Short low glitch is rejected at the start mid-sample
        rx = 1'b0;
        repeat (H / 2) @(negedge clk);
        rx = 1'b1;
        check("glitch_in_start", 32'(dut.state), 32'd1);
        repeat (H) @(negedge clk);
        check("glitch_state", 32'(dut.state), 32'd0);
        check("glitch_rdy", {31'd0, rdy}, 32'd0);
        check("glitch_data", {24'd0, rx_data}, 32'hFF);
        check("glitch_rise", rise_cnt, 32'd3);

        // Framing error then clean frame
        idle(B);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        idle(2 * B);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
        idle(B);
        check("fe_rise", rise_cnt, 32'd5);

        // clr_rdy on the very cycle completion sets rdy
        fork
            send_frame(8'h96, 1'b1, 1'b1, 1'b0);
            begin
                repeat (lat - 1) @(negedge clk);
                clr_rdy = 1'b1;
                @(negedge clk);
                clr_rdy = 1'b0;
                @(negedge clk);
                check("clr_vs_done", {31'd0, rdy}, 32'd1);
            end
        join
        idle(B);
        check("clr_vs_done_rise", rise_cnt, 32'd6);

        // Break: RX held low for longer than a frame
        exp_q.push_back({1'b1, 8'h00});
        rx = 1'b0;
        repeat (11 * B) @(negedge clk);
        idle(2 * B);
        check("break_rise", rise_cnt, 32'd7);

        // Reset in the middle of data bit 4 of 8'h5A
        pf = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = pf[i];
            repeat (B) @(negedge clk);
        end
        rx = pf[5];
        repeat (B / 2) @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        idle(12 * B);
        check("mid_rst_rdy", {31'd0, rdy}, 32'd0);
        check("mid_rst_data", {24'd0, rx_data}, 32'd0);
        check("mid_rst_frm", {31'd0, frm_err}, 32'd0);
        check("mid_rst_rise", rise_cnt, 32'd7);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        idle(B);
        check("post_rst_rise", rise_cnt, 32'd8);

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
